// File: rtl/diagv2_dmem_responder_pkg.sv
// Shared constants for the diag-v2 data-memory responder.
// Contents: access-type encodings, default MMIO addresses and lane/alignment helpers.
package diagv2_dmem_responder_pkg;

   localparam int DataBusBits    = 64;
   localparam int MemTypeBusBits = 3;

   localparam logic [2:0] MEM_B  = 3'b000;
   localparam logic [2:0] MEM_H  = 3'b001;
   localparam logic [2:0] MEM_W  = 3'b010;
   localparam logic [2:0] MEM_D  = 3'b011;
   localparam logic [2:0] MEM_BU = 3'b100;
   localparam logic [2:0] MEM_HU = 3'b101;
   localparam logic [2:0] MEM_WU = 3'b110;

   localparam logic [63:0] DEFAULT_CONSOLE_ADDR = 64'h0000_0000_1000_0000;
   localparam logic [63:0] DEFAULT_EXIT_ADDR    = 64'h0000_0000_1000_0008;

   typedef enum logic [1:0] {
      REGION_NONE,
      REGION_RAM,
      REGION_CONSOLE,
      REGION_EXIT
   } region_e;

   // Low address bits that must be zero for an access of the given size code.
   function automatic logic [2:0] alignMask(input logic [1:0] sizeCode);
      case (sizeCode)
         2'd0:    return 3'b000;
         2'd1:    return 3'b001;
         2'd2:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   function automatic logic [7:0] laneMask(input logic [1:0] sizeCode);
      case (sizeCode)
         2'd0:    return 8'h01;
         2'd1:    return 8'h03;
         2'd2:    return 8'h0F;
         default: return 8'hFF;
      endcase
   endfunction

endpackage

// File: rtl/diagv2_dmem_responder_console_fifo.sv
// Power-of-two synchronous FIFO with occupancy count.
// Storage is not reset; only pointers and count are cleared.
module console_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PtrBits = $clog2(DEPTH);
   localparam logic [PtrBits:0] DepthCount = (PtrBits + 1)'(DEPTH);

   logic [WIDTH-1:0]   store_q [DEPTH];
   logic [PtrBits-1:0] wrPtr_q, wrPtr_d;
   logic [PtrBits-1:0] rdPtr_q, rdPtr_d;
   logic [PtrBits:0]   count_q, count_d;
   logic               doPush, doPop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == DepthCount);
   assign doPop   = pop_i && !empty_o;
   assign doPush  = push_i && (!full_o || doPop);
   assign data_o  = store_q[rdPtr_q];
   assign count_o = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) store_q[wrPtr_q] <= data_i;
   end

endmodule

// File: rtl/diagv2_dmem_responder.sv
// Zero-wait data-memory slave for the diag-v2 core: byte-lane RAM plus console/exit MMIO.
// Every access completes in its own cycle; stores commit at the rising edge.
module diagv2_dmem_responder
   import diagv2_dmem_responder_pkg::*;
#(
   parameter int          MEM_WORDS    = 4096,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [63:0] CONSOLE_ADDR = DEFAULT_CONSOLE_ADDR,
   parameter logic [63:0] EXIT_ADDR    = DEFAULT_EXIT_ADDR
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [DataBusBits-1:0]    addr,
   input  logic [DataBusBits-1:0]    writeData,
   input  logic                      memWrite,
   input  logic [MemTypeBusBits-1:0] memType,
   output logic [DataBusBits-1:0]    readData,
   output logic                      con_valid,
   output logic [7:0]                con_data,
   input  logic                      con_ready,
   output logic                      exit_valid,
   output logic [DataBusBits-1:0]    exit_code,
   output logic                      misaligned,
   output logic                      overflow
);

   localparam int          IdxBits  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam int          CntBits  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [63:0] RamBytes = 64'(MEM_WORDS) * 64'd8;

   logic [63:0]        mem [MEM_WORDS];
   logic [IdxBits-1:0] ramIdx;
   logic [2:0]         lane;
   logic               aligned;
   region_e            region;
   logic [63:0]        ramWord, laneData, wrData;
   logic [7:0]         byteEn;
   logic               storeEn, ramWe, conPush, exitWe;
   logic               conPop, conFull, conEmpty;
   logic [7:0]         conHead;
   logic [CntBits-1:0] conCount;
   logic               exitValid_q, exitValid_d;
   logic [63:0]        exitCode_q, exitCode_d;
   logic               misaligned_q, misaligned_d;
   logic               overflow_q, overflow_d;

   assign ramIdx   = addr[3 +: IdxBits];
   assign lane     = addr[2:0];
   assign aligned  = ((addr[2:0] & alignMask(memType[1:0])) == 3'b000);
   assign ramWord  = mem[ramIdx];
   assign laneData = ramWord >> {lane, 3'b000};
   assign byteEn   = laneMask(memType[1:0]) << lane;
   assign wrData   = writeData << {lane, 3'b000};

   // MMIO registers take priority so they stay reachable if the RAM is ever sized over them.
   always_comb begin
      region = REGION_NONE;
      if (addr == CONSOLE_ADDR)   region = REGION_CONSOLE;
      else if (addr == EXIT_ADDR) region = REGION_EXIT;
      else if (addr < RamBytes)   region = REGION_RAM;
   end

   assign storeEn = memWrite && aligned;
   assign ramWe   = storeEn && (region == REGION_RAM);
   assign conPush = storeEn && (region == REGION_CONSOLE);
   assign exitWe  = storeEn && (region == REGION_EXIT);
   assign conPop  = con_valid && con_ready;

   always_comb begin
      readData = '0;
      if (aligned) begin
         case (region)
            REGION_RAM: begin
               case (memType)
                  MEM_B:   readData = {{56{laneData[7]}}, laneData[7:0]};
                  MEM_H:   readData = {{48{laneData[15]}}, laneData[15:0]};
                  MEM_W:   readData = {{32{laneData[31]}}, laneData[31:0]};
                  MEM_D:   readData = laneData;
                  MEM_BU:  readData = {56'b0, laneData[7:0]};
                  MEM_HU:  readData = {48'b0, laneData[15:0]};
                  MEM_WU:  readData = {32'b0, laneData[31:0]};
                  default: readData = laneData;
               endcase
            end
            REGION_CONSOLE: readData = 64'(conCount);
            REGION_EXIT:    readData = exitCode_q;
            default:        readData = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ramWe) begin
         for (int i = 0; i < 8; i++) begin
            if (byteEn[i]) mem[ramIdx][i*8 +: 8] <= wrData[i*8 +: 8];
         end
      end
   end

   console_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_console_fifo (
      .clk     (clk),
      .rst_n   (reset),
      .push_i  (conPush),
      .pop_i   (conPop),
      .data_i  (writeData[7:0]),
      .data_o  (conHead),
      .full_o  (conFull),
      .empty_o (conEmpty),
      .count_o (conCount)
   );

   // A full FIFO still takes a byte when the sink drains the head in the same cycle.
   always_comb begin
      exitValid_d  = exitValid_q;
      exitCode_d   = exitCode_q;
      misaligned_d = misaligned_q | !aligned;
      overflow_d   = overflow_q | (conPush && conFull && !conPop);
      if (exitWe) begin
         exitValid_d = 1'b1;
         exitCode_d  = writeData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exitValid_q  <= 1'b0;
         exitCode_q   <= '0;
         misaligned_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         exitValid_q  <= exitValid_d;
         exitCode_q   <= exitCode_d;
         misaligned_q <= misaligned_d;
         overflow_q   <= overflow_d;
      end
   end

   assign con_valid  = !conEmpty;
   assign con_data   = conEmpty ? 8'h00 : conHead;
   assign exit_valid = exitValid_q;
   assign exit_code  = exitCode_q;
   assign misaligned = misaligned_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_diagv2_dmem_responder.sv
// Directed bench for diagv2_dmem_responder: RAM lanes, misalignment, console FIFO, exit, reset.
// Load results and console bytes are predicted into queues and compared as the DUT produces them.
module tb_diagv2_dmem_responder;
   import diagv2_dmem_responder_pkg::*;

   localparam logic [63:0] ConsoleAddr = 64'h1000_0000;
   localparam logic [63:0] ExitAddr    = 64'h1000_0008;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] addr, writeData, readData, exit_code;
   logic        memWrite, con_valid, con_ready, exit_valid, misaligned, overflow;
   logic [2:0]  memType;
   logic [7:0]  con_data;

   int checks = 0;
   int errors = 0;
   logic [63:0] loadQ[$];
   logic [7:0]  conQ[$];

   diagv2_dmem_responder dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .writeData  (writeData),
      .memWrite   (memWrite),
      .memType    (memType),
      .readData   (readData),
      .con_valid  (con_valid),
      .con_data   (con_data),
      .con_ready  (con_ready),
      .exit_valid (exit_valid),
      .exit_code  (exit_code),
      .misaligned (misaligned),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Compares one observed value against the bench's own expectation.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [63:0] a, input logic [63:0] d, input logic [2:0] t);
      addr = a; writeData = d; memType = t; memWrite = 1'b1;
      tick();
      memWrite = 1'b0; addr = 64'h0; memType = MEM_D;
   endtask

   task automatic loadCheck(input string tag, input logic [63:0] a, input logic [2:0] t, input logic [63:0] exp);
      logic [63:0] want;
      addr = a; memType = t; memWrite = 1'b0;
      loadQ.push_back(exp);
      #1;
      want = loadQ.pop_front();
      checkOutput(tag, readData, want);
      tick();
   endtask

   task automatic conStore(input logic [7:0] ch, input bit accept);
      if (accept) conQ.push_back(ch);
      applyStimulus(ConsoleAddr, {56'h0, ch}, MEM_B);
   endtask

   // Drains n predicted bytes, one per cycle, then expects the FIFO empty.
   task automatic drain(input string tag, input int n);
      logic [7:0] want;
      con_ready = 1'b1;
      for (int c = 0; c < n; c++) begin
         #1;
         want = (conQ.size() != 0) ? conQ.pop_front() : 8'hxx;
         checkOutput($sformatf("%s valid %0d", tag, c), {63'b0, con_valid}, 64'd1);
         checkOutput($sformatf("%s data %0d", tag, c), {56'b0, con_data}, {56'b0, want});
         tick();
      end
      con_ready = 1'b0;
      #1;
      checkOutput({tag, " empty"}, {63'b0, con_valid}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=timeout required=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] want;
      reset = 1'b0; addr = 64'h0; writeData = 64'h0; memWrite = 1'b0;
      memType = MEM_D; con_ready = 1'b0;
      tick(); tick();
      checkOutput("rst con_valid", {63'b0, con_valid}, 64'd0);
      checkOutput("rst con_data", {56'b0, con_data}, 64'd0);
      checkOutput("rst exit_valid", {63'b0, exit_valid}, 64'd0);
      checkOutput("rst exit_code", exit_code, 64'd0);
      checkOutput("rst misaligned", {63'b0, misaligned}, 64'd0);
      checkOutput("rst overflow", {63'b0, overflow}, 64'd0);
      reset = 1'b1;
      tick();

      // RAM lane extraction and sign/zero extension
      applyStimulus(64'h100, 64'h1122334455667788, MEM_D);
      loadCheck("LD 0x100", 64'h100, MEM_D, 64'h1122334455667788);
      loadCheck("LBU 0x103", 64'h103, MEM_BU, 64'h55);
      loadCheck("LH 0x106", 64'h106, MEM_H, 64'h1122);
      loadCheck("LWU 0x104", 64'h104, MEM_WU, 64'h11223344);
      loadCheck("LW 0x100", 64'h100, MEM_W, 64'h55667788);
      loadCheck("LB 0x107", 64'h107, MEM_B, 64'h11);

      // Same-cycle load sees old data, next cycle sees new
      addr = 64'h100; writeData = 64'hA5A5_0000_FFFF_1234; memType = MEM_D; memWrite = 1'b1;
      loadQ.push_back(64'h1122334455667788);
      #1;
      want = 8'h0;
      checkOutput("store-cycle old data", readData, loadQ.pop_front());
      tick();
      memWrite = 1'b0;
      loadCheck("LD after store", 64'h100, MEM_D, 64'hA5A5_0000_FFFF_1234);

      // Byte/half merge into a zeroed word
      applyStimulus(64'h200, 64'h0, MEM_D);
      applyStimulus(64'h200, 64'hFFFF_FFFF_FFFF_FF80, MEM_B);
      loadCheck("LB 0x200", 64'h200, MEM_B, 64'hFFFF_FFFF_FFFF_FF80);
      loadCheck("LBU 0x200", 64'h200, MEM_BU, 64'h80);
      applyStimulus(64'h202, 64'h0000_0000_0000_BEEF, MEM_H);
      loadCheck("LD 0x200", 64'h200, MEM_D, 64'h0000_0000_BEEF_0080);
      loadCheck("LW 0x200", 64'h200, MEM_W, 64'hFFFF_FFFF_BEEF_0080);
      loadCheck("LH 0x202", 64'h202, MEM_H, 64'hFFFF_FFFF_FFFF_BEEF);
      loadCheck("LHU 0x202", 64'h202, MEM_HU, 64'h0000_0000_0000_BEEF);

      // RAM top boundary and unmapped space
      applyStimulus(64'h7FF8, 64'h0123_4567_89AB_CDEF, MEM_D);
      loadCheck("LD last word", 64'h7FF8, MEM_D, 64'h0123_4567_89AB_CDEF);
      loadCheck("LD past RAM", 64'h8000, MEM_D, 64'h0);
      applyStimulus(64'h2000_0000, 64'h55, MEM_D);
      loadCheck("LD unmapped", 64'h2000_0000, MEM_D, 64'h0);
      checkOutput("no misaligned yet", {63'b0, misaligned}, 64'd0);

      // Nine bytes into a stalled console: the ninth is dropped
      for (int i = 0; i < 9; i++) begin
         conStore(8'h41 + 8'(i), i < 8);
         if (i == 7) checkOutput("overflow at full", {63'b0, overflow}, 64'd0);
      end
      checkOutput("overflow after drop", {63'b0, overflow}, 64'd1);
      loadCheck("console count full", ConsoleAddr, MEM_D, 64'd8);
      drain("drainA", 8);

      reset = 1'b0;
      #1;
      checkOutput("reset clears overflow", {63'b0, overflow}, 64'd0);
      reset = 1'b1;
      conQ.delete();
      tick();

      // Full FIFO with a simultaneous pop and push
      for (int i = 0; i < 8; i++) conStore(8'h41 + 8'(i), 1'b1);
      checkOutput("full no overflow", {63'b0, overflow}, 64'd0);
      addr = ConsoleAddr; writeData = 64'h5A; memType = MEM_B; memWrite = 1'b1; con_ready = 1'b1;
      #1;
      want = conQ.pop_front();
      checkOutput("pop during push", {56'b0, con_data}, {56'b0, want});
      conQ.push_back(8'h5A);
      tick();
      memWrite = 1'b0; con_ready = 1'b0;
      loadCheck("count after push+pop", ConsoleAddr, MEM_D, 64'd8);
      checkOutput("overflow after push+pop", {63'b0, overflow}, 64'd0);
      drain("drainB", 8);

      // Misaligned store is suppressed and flagged
      applyStimulus(64'h101, 64'hFFFF, MEM_H);
      checkOutput("misaligned set", {63'b0, misaligned}, 64'd1);
      loadCheck("word kept", 64'h100, MEM_D, 64'hA5A5_0000_FFFF_1234);
      loadCheck("LW 0x102 zero", 64'h102, MEM_W, 64'h0);
      addr = 64'h0; memType = MEM_D;
      tick();
      checkOutput("misaligned held", {63'b0, misaligned}, 64'd1);

      // Exit register
      addr = ExitAddr; writeData = 64'd42; memType = MEM_D; memWrite = 1'b1;
      #1;
      checkOutput("exit before edge", {63'b0, exit_valid}, 64'd0);
      tick();
      memWrite = 1'b0; addr = 64'h0;
      checkOutput("exit_valid", {63'b0, exit_valid}, 64'd1);
      checkOutput("exit_code 42", exit_code, 64'd42);
      applyStimulus(ExitAddr, 64'd7, MEM_D);
      checkOutput("exit_code update", exit_code, 64'd7);

      // Reset asserted while the console is draining
      conStore(8'h78, 1'b1);
      conStore(8'h79, 1'b1);
      conStore(8'h7A, 1'b1);
      con_ready = 1'b1;
      #1;
      want = conQ.pop_front();
      checkOutput("mid-drain head", {56'b0, con_data}, {56'b0, want});
      tick();
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async con_valid", {63'b0, con_valid}, 64'd0);
      checkOutput("async con_data", {56'b0, con_data}, 64'd0);
      checkOutput("async exit_valid", {63'b0, exit_valid}, 64'd0);
      checkOutput("async exit_code", exit_code, 64'd0);
      checkOutput("async misaligned", {63'b0, misaligned}, 64'd0);
      checkOutput("async overflow", {63'b0, overflow}, 64'd0);
      con_ready = 1'b0;
      conQ.delete();
      reset = 1'b1;
      tick();
      loadCheck("RAM survives reset", 64'h200, MEM_D, 64'h0000_0000_BEEF_0080);
      loadCheck("count after reset", ConsoleAddr, MEM_D, 64'd0);
      checkOutput("con_valid after reset", {63'b0, con_valid}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
